// File: rtl/int_sqrt_seq_pkg.sv
// Shared types and sizing helpers for the sequential integer square root.
// The default radicand width comes from BYTE_BITS.
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

package int_sqrt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } int_sqrt_state_t;

    typedef enum logic {
        SQRT_FLOOR = 1'b0,
        SQRT_ROUND = 1'b1
    } sqrt_mode_t;

    // Iteration counter width; at least one bit even for a single iteration
    function automatic int unsigned cnt_bits(input int unsigned root_bits);
        return (root_bits > 1) ? $clog2(root_bits) : 1;
    endfunction

endpackage

// File: rtl/int_sqrt_seq_fsm.sv
// Control for int_sqrt_seq: IDLE/CALC/DONE state, iteration counter and
// the load/step/last strobes handed to the datapath.
module int_sqrt_seq_fsm
    import int_sqrt_seq_pkg::*;
#(
    parameter int unsigned ROOT_BITS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic trigger,
    output logic rdy_o,
    output logic done_o,
    output logic load_o,
    output logic step_o,
    output logic last_o
);

    localparam int unsigned CNT_W = cnt_bits(ROOT_BITS);

    int_sqrt_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_o   = 1'b0;
        done_o  = 1'b0;
        load_o  = 1'b0;
        step_o  = 1'b0;
        last_o  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                rdy_o  = 1'b1;
                done_o = (state_q == DONE);
                if (trigger && clk_en) begin
                    load_o  = 1'b1;
                    cnt_d   = CNT_W'(ROOT_BITS - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                step_o = clk_en;
                last_o = (cnt_q == '0);
                if (clk_en) begin
                    if (cnt_q == '0) state_d = DONE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/int_sqrt_seq.sv
// Sequential digit-by-digit integer square root, one root bit per enabled clock.
// Define INT_SQRT_REM_EN to expose the floor remainder on rem_out.
module int_sqrt_seq
    import int_sqrt_seq_pkg::*;
#(
    parameter  int unsigned NUM_BITS  = `BYTE_BITS,
    localparam int unsigned ROOT_BITS = (NUM_BITS + 1) / 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic [NUM_BITS-1:0]  num_in,
    input  logic                 mode_in,
    input  logic                 trigger,
    output logic [ROOT_BITS:0]   sqrt_out,
    output logic                 done,
    output logic                 rdy
`ifdef INT_SQRT_REM_EN
    ,output logic [ROOT_BITS:0]  rem_out
`endif
);

    localparam int unsigned RAD_W = 2 * ROOT_BITS;
    localparam int unsigned REM_W = ROOT_BITS + 2;

    logic [RAD_W-1:0]     rad_q, rad_d;
    logic [REM_W-1:0]     rem_q, rem_d;
    logic [REM_W-1:0]     rem_sh, trial;
    logic [ROOT_BITS-1:0] root_q, root_d;
    sqrt_mode_t           mode_q, mode_d;
    logic                 load, step, last, ge, round_bit;

    int_sqrt_seq_fsm #(.ROOT_BITS(ROOT_BITS)) u_fsm (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .trigger (trigger),
        .rdy_o   (rdy),
        .done_o  (done),
        .load_o  (load),
        .step_o  (step),
        .last_o  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            mode_q <= SQRT_FLOOR;
        end else if (clk_en) begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            mode_q <= mode_d;
        end
    end

    // One restoring step: bring down two radicand bits, try (root<<2)|1
    always_comb begin
        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        mode_d = mode_q;
        rem_sh = {rem_q[ROOT_BITS-1:0], rad_q[RAD_W-1 -: 2]};
        trial  = {root_q, 2'b01};
        ge     = (rem_sh >= trial);
        if (load) begin
            rad_d  = RAD_W'(num_in);
            mode_d = sqrt_mode_t'(mode_in);
            rem_d  = '0;
            root_d = '0;
        end else if (step) begin
            rem_d  = ge ? (rem_sh - trial) : rem_sh;
            root_d = ROOT_BITS'({root_q, ge});
            rad_d  = last ? '0 : (rad_q << 2);
        end
    end

    // Round up when num > root^2 + root, i.e. the true root is past root + 0.5
    assign round_bit = (mode_q == SQRT_ROUND) && (rem_q > REM_W'(root_q));
    assign sqrt_out  = {1'b0, root_q} + (ROOT_BITS + 1)'(round_bit);

`ifdef INT_SQRT_REM_EN
    assign rem_out = rem_q[ROOT_BITS:0];
`endif

endmodule

// File: tb/tb_int_sqrt_seq.sv
// Scoreboard bench for int_sqrt_seq: 8-bit and 9-bit instances run in lock-step
// against an arithmetic reference model.
module tb_int_sqrt_seq;

    localparam int unsigned R8 = 4;
    localparam int unsigned R9 = 5;

    typedef struct {
        int root;
        int rem;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, clk_en, trigger, mode_in;
    logic [7:0]   num8;
    logic [8:0]   num9;
    logic [R8:0]  sq8;
    logic [R9:0]  sq9;
    logic         done8, rdy8, done9, rdy9;
`ifdef INT_SQRT_REM_EN
    logic [R8:0]  rem8;
    logic [R9:0]  rem9;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t q8[$];
    exp_t q9[$];
    exp_t last8, last9;
    int   lat8 = 0, lat9 = 0;
    logic dp8 = 1'b0, dp9 = 1'b0;
    int   en_mode = 0;
    int   phase = 0;

    int_sqrt_seq #(.NUM_BITS(8)) dut8 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .num_in(num8), .mode_in(mode_in),
        .trigger(trigger), .sqrt_out(sq8), .done(done8), .rdy(rdy8)
`ifdef INT_SQRT_REM_EN
        , .rem_out(rem8)
`endif
    );

    int_sqrt_seq #(.NUM_BITS(9)) dut9 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .num_in(num9), .mode_in(mode_in),
        .trigger(trigger), .sqrt_out(sq9), .done(done9), .rdy(rdy9)
`ifdef INT_SQRT_REM_EN
        , .rem_out(rem9)
`endif
    );

    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    function automatic exp_t model(input int n, input int m);
        exp_t e;
        int r = isqrt(n);
        e.rem  = n - r * r;
        e.root = (m != 0 && 4 * n >= (2 * r + 1) * (2 * r + 1)) ? r + 1 : r;
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // clk_en: always high, or high one cycle in three
    always @(negedge clk) begin
        phase   <= phase + 1;
        clk_en  <= (en_mode == 0) || (phase % 3 == 0);
    end

    // Enabled edges since the accepting edge (accept edge counts as 1)
    always @(posedge clk) begin
        if (reset) begin
            lat8 <= 0;
            lat9 <= 0;
        end else if (clk_en) begin
            lat8 <= (rdy8 && trigger) ? 1 : lat8 + 1;
            lat9 <= (rdy9 && trigger) ? 1 : lat9 + 1;
        end
    end

    // Monitor: every rising done pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (done8 && !dp8) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done8: got done with empty queue required none");
            end else begin
                e = q8.pop_front();
                check("root8", int'(sq8), e.root);
                check("latency8", lat8, R8 + 1);
`ifdef INT_SQRT_REM_EN
                check("rem8", int'(rem8), e.rem);
`endif
            end
        end
        if (done9 && !dp9) begin
            if (q9.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done9: got done with empty queue required none");
            end else begin
                e = q9.pop_front();
                check("root9", int'(sq9), e.root);
                check("latency9", lat9, R9 + 1);
`ifdef INT_SQRT_REM_EN
                check("rem9", int'(rem9), e.rem);
`endif
            end
        end
        dp8 = done8;
        dp9 = done9;
    end

    task automatic wait_rdy();
        int k = 0;
        while (!(rdy8 && rdy9) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("rdy_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!(done8 && done9) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("done_timeout", 0, 1);
    endtask

    // Issue one transaction to both instances; optionally poke trigger mid-CALC
    task automatic go(input int a8, input int a9, input int m, input bit poke);
        int k = 0;
        wait_rdy();
        num8    = 8'(a8);
        num9    = 9'(a9);
        mode_in = m[0];
        trigger = 1'b1;
        do begin
            @(posedge clk);
            k++;
        end while (!(clk_en && rdy8 && rdy9) && k < 300);
        if (k >= 300) check("accept_timeout", 0, 1);
        last8 = model(a8 & 255, m);
        last9 = model(a9 & 511, m);
        q8.push_back(last8);
        q9.push_back(last9);
        @(negedge clk);
        trigger = 1'b0;
        if (poke) begin
            check("done_low_calc", int'(done8), 0);
            check("rdy_low_calc", int'(rdy8), 0);
            num8    = 8'd0;
            num9    = 9'd0;
            trigger = 1'b1;
            repeat (3) @(negedge clk);
            trigger = 1'b0;
        end
        wait_done();
    endtask

    task automatic hold_check();
        num8    = 8'($urandom);
        num9    = 9'($urandom);
        mode_in = ~mode_in;
        repeat (3) @(negedge clk);
        check("hold8", int'(sq8), last8.root);
        check("hold9", int'(sq9), last9.root);
        check("hold_done", int'(done8 && done9), 1);
    endtask

    task automatic idle_check(input string nm);
        check({nm, "_rdy8"}, int'(rdy8), 1);
        check({nm, "_done8"}, int'(done8), 0);
        check({nm, "_sq8"}, int'(sq8), 0);
        check({nm, "_rdy9"}, int'(rdy9), 1);
        check({nm, "_done9"}, int'(done9), 0);
        check({nm, "_sq9"}, int'(sq9), 0);
`ifdef INT_SQRT_REM_EN
        check({nm, "_rem8"}, int'(rem8), 0);
        check({nm, "_rem9"}, int'(rem9), 0);
`endif
    endtask

    initial begin
        reset   = 1'b1;
        trigger = 1'b0;
        mode_in = 1'b0;
        num8    = '0;
        num9    = '0;
        repeat (2) @(negedge clk);
        idle_check("reset");
        reset = 1'b0;
        @(negedge clk);

        // Floor and round corner values
        go(0, 0, 0, 1'b0);
        go(255, 511, 0, 1'b0);
        hold_check();
        go(255, 511, 1, 1'b0);
        go(210, 210, 1, 1'b0);
        go(211, 211, 1, 1'b0);
        go(200, 200, 1, 1'b0);
        hold_check();

        // Sparse clk_en, ignored mid-CALC trigger, back-to-back from DONE
        en_mode = 1;
        go(144, 144, 0, 1'b1);
        go(99, 400, 1, 1'b1);
        en_mode = 0;
        repeat (2) @(negedge clk);

        // Reset during the second CALC cycle
        wait_rdy();
        num8    = 8'd100;
        num9    = 9'd100;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_check("abort");
        go(81, 81, 0, 1'b0);

        // Exhaustive sweep of both widths in both modes
        for (int m = 0; m < 2; m++)
            for (int n = 0; n < 512; n++)
                go(n & 255, n, m, 1'b0);

        // Random traffic with random enable pattern
        repeat (150) begin
            en_mode = int'($urandom_range(0, 1));
            go(int'($urandom_range(0, 255)), int'($urandom_range(0, 511)),
               int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("queue8_empty", q8.size(), 0);
        check("queue9_empty", q9.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
